// File: rtl/result_writeback.sv
// result_writeback: drains the systolic array's accumulator matrix into the
// unified buffer. The matrix is snapshotted on done_in, each accumulator is
// requantized (arithmetic shift right, then saturation), and the results are
// packed NUM_COMPUTE_LANES per word and streamed out over valid/ready.
//
// Optional feature: define RESULT_RELU_EN to clamp negative requantized values
// to zero before saturation, so packed lanes are never negative.
//
// State table:
//   IDLE | waiting for done_in; a done_in here starts a new drain
//   LOAD | snapshot is held; building word 0 for the write port
//   SEND | a word is presented on wr_*; advances on each accept

module result_writeback #(
    parameter int ARRAY_SIZE             = 8,
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int BUFFER_WORD_SIZE       = 16,
    parameter int NUM_COMPUTE_LANES      = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
    parameter int ADDR_WIDTH             = 8,
    parameter int SHIFT_WIDTH            = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              done_in,
    input  logic [ACCUMULATOR_DATA_WIDTH-1:0] results_arr [ARRAY_SIZE*ARRAY_SIZE],
    input  logic [SHIFT_WIDTH-1:0]            shift,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    output logic                              wr_valid,
    input  logic                              wr_ready,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic [BUFFER_WORD_SIZE-1:0]       wr_data,
    output logic                              busy,
    output logic                              drain_done,
    output logic                              overrun
);

    localparam int NUM_ELEMS  = ARRAY_SIZE * ARRAY_SIZE;
    localparam int NUM_WORDS  = NUM_ELEMS / NUM_COMPUTE_LANES;
    localparam int WORD_IDX_W = $clog2(NUM_WORDS);
    localparam int ELEM_IDX_W = $clog2(NUM_ELEMS);
    localparam int ADW        = ACCUMULATOR_DATA_WIDTH;
    localparam int CDW        = COMPUTE_DATA_WIDTH;

    // Saturation bounds expressed at accumulator width; ~MAX is the
    // two's-complement minimum of the narrow output range.
    localparam logic signed [ADW-1:0] SAT_MAX = ADW'((1 << (CDW - 1)) - 1);
    localparam logic signed [ADW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                  state;
    logic [ADW-1:0]          snap [NUM_ELEMS];
    logic [SHIFT_WIDTH-1:0]  shift_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [WORD_IDX_W-1:0]   word_idx;
    logic [WORD_IDX_W-1:0]   next_idx;

    assign next_idx = word_idx + WORD_IDX_W'(1);

    // Shift amounts at or beyond the accumulator width collapse to pure sign
    // fill rather than relying on the shifter's out-of-range behaviour.
    function automatic logic [CDW-1:0] requant(input logic signed [ADW-1:0] acc,
                                               input logic [SHIFT_WIDTH-1:0] sh);
        logic signed [ADW-1:0] v;
        if (sh >= SHIFT_WIDTH'(ADW))
            v = {ADW{acc[ADW-1]}};
        else
            v = acc >>> sh;
`ifdef RESULT_RELU_EN
        if (v[ADW-1])
            v = '0;
`endif
        if (v > SAT_MAX)
            v = SAT_MAX;
        else if (v < SAT_MIN)
            v = SAT_MIN;
        return v[CDW-1:0];
    endfunction

    // Lane 0 sits in the LSBs; word w covers elements w*LANES .. w*LANES+LANES-1.
    function automatic logic [BUFFER_WORD_SIZE-1:0] pack_word(input logic [WORD_IDX_W-1:0] w);
        logic [BUFFER_WORD_SIZE-1:0] word;
        logic [ELEM_IDX_W-1:0]       e;
        word = '0;
        for (int k = 0; k < NUM_COMPUTE_LANES; k++) begin
            e = ELEM_IDX_W'(int'(w) * NUM_COMPUTE_LANES + k);
            word[k*CDW +: CDW] = requant(snap[e], shift_q);
        end
        return word;
    endfunction

    // Drain sequencer: capture on done_in, present words, advance on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_idx   <= '0;
            shift_q    <= '0;
            base_q     <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (done_in && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (done_in) begin
                        snap    <= results_arr;
                        shift_q <= shift;
                        base_q  <= base_addr;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    word_idx <= '0;
                    wr_data  <= pack_word('0);
                    wr_addr  <= base_q;
                    wr_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (wr_ready) begin
                        if (word_idx == LAST_WORD) begin
                            wr_valid   <= 1'b0;
                            drain_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            word_idx <= next_idx;
                            wr_data  <= pack_word(next_idx);
                            wr_addr  <= base_q + ADDR_WIDTH'(next_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback. Expected words come from an
// integer model of the requantization rules (floor division, clamping,
// nibble packing); expected addresses from modular arithmetic on base_addr.
// Define RESULT_RELU_EN for both the bench and the RTL to test that build.

module tb_result_writeback;

    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_in;
    logic [15:0] results_arr [64];
    logic [4:0]  shift;
    logic [7:0]  base_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        drain_done;
    logic        overrun;

    result_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .done_in    (done_in),
        .results_arr(results_arr),
        .shift      (shift),
        .base_addr  (base_addr),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .drain_done (drain_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model inputs, captured by the bench at done_in time
    int mdl_acc [64];
    int mdl_shift;
    int mdl_base;

    // observations from the last drain
    logic [15:0] got_data [NW];
    logic [7:0]  got_addr [NW];
    int  n_acc, lat, dd_cnt, last_acc_cyc;
    bit  overlap, stall_bad, timeout, busy_first, dd_end, wv_end, busy_end, dd_after;
    int  bp_pat [6] = '{1, 0, 0, 1, 0, 1};

    function automatic logic [15:0] exp_word(input int w);
        logic [15:0] word;
        word = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            int a, v, d;
            a = mdl_acc[w*4 + k];
            if (mdl_shift >= 16) begin
                v = (a < 0) ? -1 : 0;
            end else begin
                d = 1 << mdl_shift;
                v = a / d;
                if ((a % d) != 0 && a < 0) v = v - 1;
            end
`ifdef RESULT_RELU_EN
            if (v < 0) v = 0;
`endif
            if (v > 7) v = 7;
            if (v < -8) v = -8;
            word = word | (16'(v & 15) << (4*k));
        end
        return word;
    endfunction

    function automatic logic [7:0] exp_addr(input int w);
        return 8'((mdl_base + w) % 256);
    endfunction

    task automatic set_elem(input int i, input int val);
        results_arr[i] = 16'(val);
        mdl_acc[i]     = val;
    endtask

    task automatic set_cfg(input int sh, input int base);
        shift     = 5'(sh);
        base_addr = 8'(base);
        mdl_shift = sh;
        mdl_base  = base;
    endtask

    // rmode: 0 always ready, 1 fixed stall pattern, 2 random ready.
    // inject: 0 none, 1 second done_in at word 3 plus input scramble,
    //         2 stop after six accepts (caller applies reset).
    task automatic drain(input int rmode, input int inject);
        int  cyc, pi;
        bit  prev_stall, fired, rdy;
        logic [15:0] pd;
        logic [7:0]  pa;
        n_acc = 0; dd_cnt = 0; lat = -1; last_acc_cyc = -1;
        overlap = 0; stall_bad = 0; timeout = 0; fired = 0; prev_stall = 0; pi = 0;
        pd = '0; pa = '0;
        done_in = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
        cyc = 1;
        busy_first = busy;
        if (inject == 1) begin
            for (int i = 0; i < 64; i++) results_arr[i] = 16'h0000;
            shift     = 5'd0;
            base_addr = 8'h55;
        end
        while (n_acc < NW) begin
            if (inject == 2 && n_acc == 6) break;
            if (wr_valid && lat < 0) lat = cyc;
            if (drain_done) dd_cnt++;
            if (drain_done && wr_valid) overlap = 1;
            if (prev_stall && (wr_valid !== 1'b1 || wr_data !== pd || wr_addr !== pa)) stall_bad = 1;
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = bp_pat[pi % 6] != 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pi++;
            wr_ready = rdy;
            if (inject == 1 && n_acc == 3 && !fired) begin
                done_in = 1'b1;
                fired   = 1;
            end else begin
                done_in = 1'b0;
            end
            prev_stall = wr_valid && !rdy;
            pd = wr_data;
            pa = wr_addr;
            if (wr_valid && rdy) begin
                got_data[n_acc] = wr_data;
                got_addr[n_acc] = wr_addr;
                n_acc++;
                last_acc_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 600) begin
                timeout = 1;
                break;
            end
        end
        wr_ready = 1'b0;
        done_in  = 1'b0;
        if (n_acc == NW) begin
            dd_end   = drain_done;
            wv_end   = wr_valid;
            busy_end = busy;
            if (drain_done) dd_cnt++;
            @(posedge clk); #1;
            dd_after = drain_done;
            if (drain_done) dd_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; done_in = 1'b0; wr_ready = 1'b0;
        set_cfg(0, 0);
        for (int i = 0; i < 64; i++) set_elem(i, 0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({wr_valid, busy, drain_done, overrun} !== 4'b0000 || wr_addr !== 8'h00 || wr_data !== 16'h0000)
            $display("FAIL reset_outputs got v=%b b=%b dd=%b ov=%b a=%h d=%h want all 0",
                     wr_valid, busy, drain_done, overrun, wr_addr, wr_data);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 64; i++) set_elem(i, 16*i);
        set_cfg(4, 8'h10);
        drain(0, 0);
        n_total++;
        if (timeout !== 1'b0 || n_acc != NW) $display("FAIL basic_count got %0d accepts want %0d", n_acc, NW);
        else n_pass++;
        n_total++;
        if (lat != 2) $display("FAIL basic_latency got %0d want 2", lat); else n_pass++;
        n_total++;
        if (busy_first !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_first); else n_pass++;
        n_total++;
        if (got_data[0] !== 16'h3210 || got_data[1] !== 16'h7654)
            $display("FAIL basic_first_words got %h %h want 3210 7654", got_data[0], got_data[1]);
        else n_pass++;
        for (int w = 0; w < NW; w++) begin
            n_total++;
            if (got_data[w] !== exp_word(w) || got_addr[w] !== exp_addr(w))
                $display("FAIL basic_word w=%0d got %h@%h want %h@%h", w, got_data[w], got_addr[w], exp_word(w), exp_addr(w));
            else n_pass++;
        end
        n_total++;
        if (last_acc_cyc - lat != NW - 1) $display("FAIL basic_back_to_back got span %0d want %0d", last_acc_cyc - lat, NW - 1);
        else n_pass++;
        n_total++;
        if (dd_end !== 1'b1 || wv_end !== 1'b0 || busy_end !== 1'b0 || dd_after !== 1'b0 || dd_cnt != 1 || overlap)
            $display("FAIL basic_drain_done got dd=%b v=%b b=%b next=%b cnt=%0d want 1 0 0 0 1", dd_end, wv_end, busy_end, dd_after, dd_cnt);
        else n_pass++;
    endtask

    task automatic test_neg_shift();
        logic [15:0] want_a, want_b;
`ifdef RESULT_RELU_EN
        want_a = 16'h0000; want_b = 16'h0000;
`else
        want_a = 16'h8888; want_b = 16'hFFFF;
`endif
        for (int i = 0; i < 64; i++) set_elem(i, -1000);
        set_cfg(0, 8'h20);
        drain(0, 0);
        for (int w = 0; w < NW; w++) begin
            n_total++;
            if (got_data[w] !== want_a) $display("FAIL neg_sat w=%0d got %h want %h", w, got_data[w], want_a);
            else n_pass++;
        end
        for (int i = 0; i < 64; i++) set_elem(i, -1);
        set_cfg(20, 8'h30);
        drain(0, 0);
        for (int w = 0; w < NW; w++) begin
            n_total++;
            if (got_data[w] !== want_b || got_data[w] !== exp_word(w))
                $display("FAIL big_shift w=%0d got %h want %h", w, got_data[w], want_b);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 64; i++) set_elem(i, int'($urandom_range(0, 400)) - 200);
        set_cfg(3, 8'h40);
        drain(1, 0);
        n_total++;
        if (timeout !== 1'b0 || n_acc != NW || stall_bad !== 1'b0)
            $display("FAIL bp_stall got accepts=%0d unstable=%b want %0d 0", n_acc, stall_bad, NW);
        else n_pass++;
        for (int w = 0; w < NW; w++) begin
            n_total++;
            if (got_data[w] !== exp_word(w) || got_addr[w] !== exp_addr(w))
                $display("FAIL bp_word w=%0d got %h@%h want %h@%h", w, got_data[w], got_addr[w], exp_word(w), exp_addr(w));
            else n_pass++;
        end
        n_total++;
        if (dd_cnt != 1 || overlap) $display("FAIL bp_drain_done got %0d pulses want 1", dd_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 64; i++) set_elem(i, i - 32);
        set_cfg(2, 8'hF8);
        drain(0, 0);
        for (int w = 0; w < NW; w++) begin
            n_total++;
            if (got_addr[w] !== 8'(8'hF8 + w) || got_data[w] !== exp_word(w))
                $display("FAIL wrap_word w=%0d got %h@%h want %h@%h", w, got_data[w], got_addr[w], exp_word(w), 8'(8'hF8 + w));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int errs;
            for (int i = 0; i < 64; i++) set_elem(i, int'($urandom_range(0, 65535)) - 32768);
            set_cfg(int'($urandom_range(0, 20)), int'($urandom_range(0, 255)));
            drain(2, 0);
            errs = 0;
            for (int w = 0; w < NW; w++)
                if (got_data[w] !== exp_word(w) || got_addr[w] !== exp_addr(w)) errs++;
            n_total++;
            if (timeout !== 1'b0 || n_acc != NW || errs != 0 || stall_bad || dd_cnt != 1)
                $display("FAIL random_drain r=%0d got accepts=%0d bad_words=%0d unstable=%b dd=%0d want %0d 0 0 1",
                         r, n_acc, errs, stall_bad, dd_cnt, NW);
            else n_pass++;
        end
    endtask

    task automatic test_overrun_isolation();
        for (int i = 0; i < 64; i++) set_elem(i, 16*i);
        set_cfg(4, 8'h10);
        drain(0, 1);
        n_total++;
        if (overrun !== 1'b1) $display("FAIL overrun_flag got %b want 1", overrun); else n_pass++;
        n_total++;
        if (timeout !== 1'b0 || n_acc != NW || dd_cnt != 1) $display("FAIL overrun_count got %0d accepts want %0d", n_acc, NW);
        else n_pass++;
        for (int w = 0; w < NW; w++) begin
            n_total++;
            if (got_data[w] !== exp_word(w) || got_addr[w] !== 8'(8'h10 + w))
                $display("FAIL isolation_word w=%0d got %h@%h want %h@%h", w, got_data[w], got_addr[w], exp_word(w), 8'(8'h10 + w));
            else n_pass++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (overrun !== 1'b1 || wr_valid !== 1'b0) $display("FAIL overrun_sticky got ov=%b v=%b want 1 0", overrun, wr_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        bit spurious;
        for (int i = 0; i < 64; i++) set_elem(i, 5*i - 100);
        set_cfg(1, 8'h80);
        drain(0, 2);
        n_total++;
        if (n_acc != 6 || got_addr[5] !== 8'h85) $display("FAIL mid_pre got %0d accepts last %h want 6 85", n_acc, got_addr[5]);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0)
            $display("FAIL mid_reset got v=%b b=%b ov=%b want 0 0 0", wr_valid, busy, overrun);
        else n_pass++;
        rst = 1'b0;
        spurious = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (wr_valid !== 1'b0 || drain_done !== 1'b0) spurious = 1;
        end
        n_total++;
        if (spurious) $display("FAIL mid_quiet got activity after reset want none"); else n_pass++;
        for (int i = 0; i < 64; i++) set_elem(i, 100 - 3*i);
        set_cfg(2, 8'hC4);
        drain(0, 0);
        for (int w = 0; w < NW; w++) begin
            n_total++;
            if (got_data[w] !== exp_word(w) || got_addr[w] !== exp_addr(w))
                $display("FAIL restart_word w=%0d got %h@%h want %h@%h", w, got_data[w], got_addr[w], exp_word(w), exp_addr(w));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_shift();
        test_backpressure();
        test_wrap();
        test_random();
        test_overrun_isolation();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Drains the 8x8 accumulator matrix produced by the systolic PE controller into the unified buffer.
- On the controller's done pulse, snapshots the full results matrix.
- Requantizes each 16-bit signed accumulator to 4-bit signed using an arithmetic shift followed by saturation.
- Packs NUM_COMPUTE_LANES values per buffer word and streams the words to the buffer write port over a valid/ready handshake.

Parameters:
- ARRAY_SIZE, 8, systolic array dimension; matrix holds ARRAY_SIZE*ARRAY_SIZE elements.
- COMPUTE_DATA_WIDTH, 4, width of each requantized output element.
- ACCUMULATOR_DATA_WIDTH, 16, width of each incoming accumulator.
- BUFFER_WORD_SIZE, 16, buffer word width.
- NUM_COMPUTE_LANES, BUFFER_WORD_SIZE/COMPUTE_DATA_WIDTH, elements per word (4).
- ADDR_WIDTH, 8, buffer address width.
- SHIFT_WIDTH, 5, width of the requantization shift amount.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- done_in  in  1  one-cycle pulse from PE controller: results_arr is valid
- results_arr  in  ACCUMULATOR_DATA_WIDTH x ARRAY_SIZE*ARRAY_SIZE  signed accumulator matrix, row-major, element i
- shift  in  SHIFT_WIDTH  arithmetic right-shift amount; latched at capture
- base_addr  in  ADDR_WIDTH  buffer address for word 0; latched at capture
- wr_valid  out  1  wr_addr/wr_data hold a word
- wr_ready  in  1  buffer accepts the word this cycle
- wr_addr  out  ADDR_WIDTH  buffer write address
- wr_data  out  BUFFER_WORD_SIZE  packed requantized word
- busy  out  1  drain in progress
- drain_done  out  1  one-cycle pulse after the last word is accepted
- overrun  out  1  sticky: done_in arrived while busy

Behaviour:
- Reset: all outputs are 0, state IDLE, word index 0, snapshot contents don't-care. Reset mid-stream aborts immediately; no further words are issued.
- States and transitions:
  - IDLE -> LOAD when done_in=1 at an edge. At that edge: snapshot all results_arr elements, latch shift and base_addr, busy<=1.
  - LOAD: register word 0 into wr_data, wr_addr<=base_addr, wr_valid<=1, then go to SEND. wr_valid is first high in the 2nd cycle after done_in is sampled.
  - SEND, on accept (wr_valid & wr_ready at an edge):
    - If w < NUM_WORDS-1: register word w+1 and address; wr_valid stays 1. Back-to-back gives 1 word per cycle.
    - If w == NUM_WORDS-1: wr_valid<=0, drain_done<=1, busy<=0, go to IDLE.
  - SEND, no accept: wr_valid, wr_addr and wr_data hold stable.
  - In the drain_done cycle the block is IDLE; a done_in in that cycle is accepted.
- NUM_WORDS = ARRAY_SIZE*ARRAY_SIZE/NUM_COMPUTE_LANES (16).
- Packing: word w, lane k holds element w*NUM_COMPUTE_LANES+k at bits [k*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH]. Lane 0 is in the LSBs.
- Requantization:
  - v = acc >>> shift, arithmetic shift, truncation toward -inf.
  - If shift >= ACCUMULATOR_DATA_WIDTH, v = sign fill (0 or -1).
  - Saturate v to [-2^(CDW-1), 2^(CDW-1)-1], i.e. [-8, 7].
- Address: wr_addr = base_addr + w, modulo 2^ADDR_WIDTH (wraps).
- Snapshot isolation: changes on results_arr, shift or base_addr after capture have no effect on the current drain.
- done_in while busy: ignored, overrun<=1, stays set until rst. The current stream is unaffected.
- drain_done is never asserted in the same cycle as wr_valid.

Optional Feature:
- Macro RESULT_RELU_EN.
- Defined: after the shift, negative v is clamped to 0, then saturated to [0, 7]. Packed lanes are never negative.
- Undefined: pure signed saturation as above.

Test Plan:
- Basic drain: results_arr[i]=16*i, shift=4, base_addr=0x10, wr_ready=1 -> 16 consecutive words. word0=0x3210, word1=0x7654, word2..15=0x7777. Addrs 0x10..0x1F. wr_valid first high 2 cycles after done_in. drain_done pulses once, the cycle after the last accept.
- Negative and shift edges: all elements -1000, shift=0 -> every word 0x8888 (0x0000 with RESULT_RELU_EN). All elements -1, shift=20 -> every word 0xFFFF (0x0000 with RELU).
- Backpressure: wr_ready pattern 1,0,0,1,0,1... -> wr_data/wr_addr stable through stalls. Exactly 16 accepts, no duplicated or skipped address.
- Address wrap: base_addr=0xF8 -> addrs 0xF8..0xFF then 0x00..0x07.
- Overrun and isolation: second done_in at word 3, and results_arr changed to all 0 after capture -> overrun=1. Stream identical to the basic-drain case.
- Reset mid-stream: rst after word 5 accepted -> next cycle wr_valid=0, busy=0, overrun=0. New done_in restarts at word 0 with the new base_addr.
